// File: rtl/ram_initiator.sv
// ram_initiator: bus-master sequencer for the processor's synchronous RAM.
// It turns one-word read/write requests into the fixed MAR/MDR bus-cycle
// sequence on the shared sysbus. Addresses the RAM does not decode are
// rejected with err.
// Optional feature macro: RAM_INITIATOR_WRVERIFY_EN. When it is defined, every
// write is read back (VACC/VBUS) and compared with the data that was written.
module ram_initiator #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic                   clock,
    input  logic                   n_reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [WORD_W-OP_W-1:0] addr,
    input  logic [WORD_W-1:0]      wdata,
    output logic [WORD_W-1:0]      rdata,
    output logic                   ack,
    output logic                   err,
    output logic                   busy,
    output logic                   load_MAR,
    output logic                   load_MDR,
    output logic                   CS,
    output logic                   R_NW,
    output logic                   MDR_bus,
    inout  wire  [WORD_W-1:0]      sysbus
);

    localparam int AW = WORD_W - OP_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WDATA  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RDBUS  = 3'd4,
        ST_RESP   = 3'd5
`ifdef RAM_INITIATOR_WRVERIFY_EN
        ,
        ST_VACC   = 3'd6,
        ST_VBUS   = 3'd7
`endif
    } state_t;

    // Every externally visible control bit, decoded from a state value.
    typedef struct packed {
        logic mar;
        logic mdr;
        logic cs;
        logic rnw;
        logic mbus;
        logic ack;
        logic busy;
        logic oe;
    } ctrl_t;

    state_t              state_r;
    state_t              state_next_s;
    ctrl_t               ctrl_r;
    logic                we_r;
    logic [AW-1:0]       addr_r;
    logic [WORD_W-1:0]   wdata_r;
    logic [WORD_W-1:0]   rdata_r;
    logic                err_r;
    logic [WORD_W-1:0]   bus_data_r;
    logic                accept_s;
    logic                mapped_s;
    logic [AW-1:0]       addr_next_s;

    // The RAM decodes the upper half of the address space, except the top two
    // words, which belong to I/O.
    function automatic logic addr_mapped(input logic [AW-1:0] a);
        logic top_half;
        logic is_io;
        top_half = a[AW-1];
        is_io    = (a == {AW{1'b1}}) || (a == {{(AW-1){1'b1}}, 1'b0});
        return top_half && !is_io;
    endfunction

    // Moore decode: strobes, ack, busy and the bus enable depend on state only.
    // At most one RAM strobe is set for any state.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_IDLE:   c = '0;
            ST_ADDR:   begin c.mar = 1'b1; c.oe = 1'b1; end
            ST_WDATA:  begin c.mdr = 1'b1; c.oe = 1'b1; end
            ST_ACCESS: begin c.cs = 1'b1; c.rnw = ~we_r; end
            ST_RDBUS:  c.mbus = 1'b1;
            ST_RESP:   c.ack = 1'b1;
`ifdef RAM_INITIATOR_WRVERIFY_EN
            ST_VACC:   begin c.cs = 1'b1; c.rnw = 1'b1; end
            ST_VBUS:   c.mbus = 1'b1;
`endif
            default:   c = '0;
        endcase
        c.busy = (s != ST_IDLE);
        return c;
    endfunction

    assign accept_s    = (state_r == ST_IDLE) && req;
    assign mapped_s    = addr_mapped(addr);
    assign addr_next_s = accept_s ? addr : addr_r;

    // Next-state logic for the bus-cycle sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    if (mapped_s) begin
                        state_next_s = ST_ADDR;
                    end else begin
                        state_next_s = ST_RESP;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (we_r) begin
                    state_next_s = ST_WDATA;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_WDATA:  state_next_s = ST_ACCESS;
            ST_ACCESS: begin
                if (we_r) begin
`ifdef RAM_INITIATOR_WRVERIFY_EN
                    state_next_s = ST_VACC;
`else
                    state_next_s = ST_RESP;
`endif
                end else begin
                    state_next_s = ST_RDBUS;
                end
            end
            ST_RDBUS:  state_next_s = ST_RESP;
            ST_RESP:   state_next_s = ST_IDLE;
`ifdef RAM_INITIATOR_WRVERIFY_EN
            ST_VACC:   state_next_s = ST_VBUS;
            ST_VBUS:   state_next_s = ST_RESP;
`endif
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State register plus registered copy of the decoded controls, so every
    // control output comes straight from a flop and always matches the state.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= ST_IDLE;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_next_s;
            ctrl_r  <= decode_ctrl(state_next_s);
        end
    end

    // Latch the request fields on acceptance; they stay stable for the sequence.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            we_r    <= 1'b0;
            addr_r  <= {AW{1'b0}};
            wdata_r <= {WORD_W{1'b0}};
        end else if (accept_s) begin
            we_r    <= we;
            addr_r  <= addr;
            wdata_r <= wdata;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Value placed on sysbus: zero-extended address in ADDR, write data in WDATA.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            bus_data_r <= {WORD_W{1'b0}};
        end else if (state_next_s == ST_WDATA) begin
            bus_data_r <= wdata_r;
        end else begin
            bus_data_r <= {{OP_W{1'b0}}, addr_next_s};
        end
    end

    // Read-data register: captures the RAM's MDR in RDBUS, cleared on a reject.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            rdata_r <= {WORD_W{1'b0}};
        end else if (accept_s && !mapped_s) begin
            rdata_r <= {WORD_W{1'b0}};
        end else if (state_r == ST_RDBUS) begin
            rdata_r <= sysbus;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Error flag: set for an unmapped address (or a failed write verify) and
    // only ever high during the RESP cycle.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            err_r <= 1'b0;
        end else if (accept_s) begin
            err_r <= ~mapped_s;
`ifdef RAM_INITIATOR_WRVERIFY_EN
        end else if (state_r == ST_VBUS) begin
            err_r <= (sysbus != wdata_r);
`endif
        end else if (state_r == ST_RESP) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    // The bus is driven only in ADDR/WDATA, never while the RAM drives it.
    assign sysbus   = ctrl_r.oe ? bus_data_r : {WORD_W{1'bz}};

    assign load_MAR = ctrl_r.mar;
    assign load_MDR = ctrl_r.mdr;
    assign CS       = ctrl_r.cs;
    assign R_NW     = ctrl_r.rnw;
    assign MDR_bus  = ctrl_r.mbus;
    assign ack      = ctrl_r.ack;
    assign busy     = ctrl_r.busy;
    assign rdata    = rdata_r;
    assign err      = err_r;

endmodule

// File: tb/tb_ram_initiator.sv
// Self-checking bench for ram_initiator: a behavioural RAM on sysbus, a
// high-level reference model (array of words), a vector table, random
// transactions and hand-written multi-cycle sequences.
module tb_ram_initiator;

`ifdef RAM_INITIATOR_WRVERIFY_EN
    localparam bit VERIFY = 1'b1;
    localparam int WL     = 6;
`else
    localparam bit VERIFY = 1'b0;
    localparam int WL     = 4;
`endif

    logic       clock   = 1'b0;
    logic       n_reset = 1'b0;
    logic       req     = 1'b0;
    logic       we      = 1'b0;
    logic [4:0] addr    = 5'd0;
    logic [7:0] wdata   = 8'h00;
    wire  [7:0] rdata;
    wire        ack, err, busy, load_MAR, load_MDR, CS, R_NW, MDR_bus;
    wire  [7:0] sysbus;

    logic       test_drv = 1'b0;
    logic       stuck0   = 1'b0;
    logic       clr_mem  = 1'b1;
    logic [7:0] mem [32];
    logic [4:0] ram_mar;
    logic [7:0] ram_mdr;

    int         total  = 0;
    int         passed = 0;
    int         cyc    = 0;
    logic [7:0] refmem [32];
    logic [7:0] ref_rdata = 8'h00;

    ram_initiator #(.WORD_W(8), .OP_W(3)) dut (
        .clock(clock), .n_reset(n_reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy),
        .load_MAR(load_MAR), .load_MDR(load_MDR), .CS(CS), .R_NW(R_NW),
        .MDR_bus(MDR_bus), .sysbus(sysbus)
    );

    always #5 clock = ~clock;

    // RAM drives its MDR when asked; the bench can also drive a marker value.
    assign sysbus = MDR_bus ? ram_mdr : (test_drv ? 8'h5A : 8'hzz);

    // Behavioural synchronous RAM with optional stuck-at-0 data bit 0.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (clr_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            ram_mar <= 5'd0;
            ram_mdr <= 8'h00;
        end else begin
            if (load_MAR) ram_mar <= sysbus[4:0];
            if (load_MDR) ram_mdr <= sysbus;
            if (CS && R_NW) ram_mdr <= mem[ram_mar];
            if (CS && !R_NW) mem[ram_mar] <= stuck0 ? (ram_mdr & 8'hFE) : ram_mdr;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic bit is_mapped(input logic [4:0] a);
        return (a >= 5'd16) && (a <= 5'd29);
    endfunction

    // Reference model: memory array plus the rule set for err/latency/rdata.
    task automatic model_step(input bit w, input logic [4:0] a, input logic [7:0] d,
                              output logic [7:0] erd, output bit eerr, output int elat);
        logic [7:0] st;
        if (!is_mapped(a)) begin
            ref_rdata = 8'h00; eerr = 1'b1; elat = 1;
        end else if (w) begin
            st = stuck0 ? (d & 8'hFE) : d;
            refmem[a] = st;
            eerr = VERIFY && (st != d);
            elat = WL;
        end else begin
            ref_rdata = refmem[a]; eerr = 1'b0; elat = 4;
        end
        erd = ref_rdata;
    endtask

    // Per-cycle activity code: 1 MAR, 2 MDR, 3 CS write, 4 CS read, 5 MDR_bus,
    // 6 ack, 7 illegal combination, 0 nothing.
    function automatic logic [2:0] cyc_code();
        int n;
        n = int'(load_MAR) + int'(load_MDR) + int'(CS) + int'(MDR_bus) + int'(ack);
        if (n > 1 || (R_NW && !CS)) return 3'd7;
        if (load_MAR) return 3'd1;
        if (load_MDR) return 3'd2;
        if (CS)       return R_NW ? 3'd4 : 3'd3;
        if (MDR_bus)  return 3'd5;
        if (ack)      return 3'd6;
        return 3'd0;
    endfunction

    function automatic logic [31:0] exp_seq(input bit w, input logic [4:0] a);
        logic [31:0] s;
        if (!is_mapped(a)) return 32'd6;
        s = 32'd1;
        if (w) begin
            s = {s[28:0], 3'd2};
            s = {s[28:0], 3'd3};
            if (VERIFY) begin
                s = {s[28:0], 3'd4};
                s = {s[28:0], 3'd5};
            end
        end else begin
            s = {s[28:0], 3'd4};
            s = {s[28:0], 3'd5};
        end
        return {s[28:0], 3'd6};
    endfunction

    task automatic do_txn(input string nm, input bit w, input logic [4:0] a, input logic [7:0] d,
                          input logic [7:0] erd, input bit eerr, input int elat);
        logic [31:0] seq;
        int          lat;
        bit          bus_bad, busy_bad;
        logic [7:0]  rd_s;
        logic        er_s;
        seq = 32'd0; lat = 0; bus_bad = 1'b0; busy_bad = 1'b0; rd_s = 8'h00; er_s = 1'b0;
        @(negedge clock);
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            seq = {seq[28:0], cyc_code()};
            if (load_MAR && sysbus !== {3'b000, a}) bus_bad = 1'b1;
            if (load_MDR && sysbus !== d) bus_bad = 1'b1;
            if ((load_MAR || load_MDR || MDR_bus) && $isunknown(sysbus)) bus_bad = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (ack) begin
                lat = n; rd_s = rdata; er_s = err; req = 1'b0;
                break;
            end
        end
        req = 1'b0;
        chk($sformatf("%s.latency", nm), lat, elat);
        chk($sformatf("%s.strobe_seq", nm), seq, exp_seq(w, a));
        chk($sformatf("%s.err", nm), {31'd0, er_s}, {31'd0, eerr});
        chk($sformatf("%s.rdata", nm), {24'd0, rd_s}, {24'd0, erd});
        chk($sformatf("%s.bus_busy", nm), {30'd0, bus_bad, busy_bad}, 32'd0);
        @(negedge clock);
        chk($sformatf("%s.idle_after", nm), {29'd0, busy, ack, err}, 32'd0);
    endtask

    typedef struct {
        bit         w;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] erd;
        bit         eerr;
        int         elat;
    } vec_t;

    initial begin
        vec_t       tbl [12];
        logic [7:0] erd;
        bit         eerr;
        int         elat;
        int         last_ack;
        bit         got, xbad;

        tbl[0]  = '{1'b1, 5'd16, 8'hA5, 8'h00, 1'b0, WL};
        tbl[1]  = '{1'b0, 5'd16, 8'h00, 8'hA5, 1'b0, 4};
        tbl[2]  = '{1'b0, 5'd5,  8'h00, 8'h00, 1'b1, 1};
        tbl[3]  = '{1'b0, 5'd30, 8'h00, 8'h00, 1'b1, 1};
        tbl[4]  = '{1'b0, 5'd31, 8'h00, 8'h00, 1'b1, 1};
        tbl[5]  = '{1'b1, 5'd29, 8'h5A, 8'h00, 1'b0, WL};
        tbl[6]  = '{1'b0, 5'd29, 8'h00, 8'h5A, 1'b0, 4};
        tbl[7]  = '{1'b1, 5'd0,  8'hFF, 8'h00, 1'b1, 1};
        tbl[8]  = '{1'b0, 5'd16, 8'h00, 8'hA5, 1'b0, 4};
        tbl[9]  = '{1'b1, 5'd28, 8'h33, 8'hA5, 1'b0, WL};
        tbl[10] = '{1'b0, 5'd15, 8'h00, 8'h00, 1'b1, 1};
        tbl[11] = '{1'b0, 5'd28, 8'h00, 8'h33, 1'b0, 4};
        for (int i = 0; i < 32; i++) refmem[i] = 8'h00;

        // Reset state: everything quiet, bus released (marker value visible).
        test_drv = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset.outputs", {24'd0, load_MAR, load_MDR, CS, R_NW, MDR_bus, ack, err, busy}, 32'd0);
        chk("reset.rdata", {24'd0, rdata}, 32'd0);
        chk("reset.sysbus_released", {24'd0, sysbus}, 32'h5A);
        test_drv = 1'b0;
        clr_mem  = 1'b0;
        @(negedge clock);
        n_reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d,
                   tbl[i].erd, tbl[i].eerr, tbl[i].elat);
            model_step(tbl[i].w, tbl[i].a, tbl[i].d, erd, eerr, elat);
        end

        // Reset pulse while in ACCESS aborts the write; RAM keeps 0xA5 at 16.
        @(negedge clock);
        req = 1'b1; we = 1'b1; addr = 5'd16; wdata = 8'h77;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clock);
            req = 1'b0;
            if (CS) got = 1'b1;
        end
        chk("abort.reached_access", {31'd0, got}, 32'd1);
        #2 n_reset = 1'b0;
        #1;
        chk("abort.immediate_idle", {27'd0, CS, busy, ack, load_MAR, load_MDR}, 32'd0);
        @(negedge clock);
        n_reset = 1'b1;
        ref_rdata = 8'h00;
        model_step(1'b0, 5'd16, 8'h00, erd, eerr, elat);
        do_txn("abort.read16", 1'b0, 5'd16, 8'h00, erd, eerr, elat);

        // Randomized transactions checked against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [4:0] ra;
            logic [7:0] rd;
            bit         rw;
            ra = ($urandom_range(3, 0) != 0) ? 5'(16 + $urandom_range(13, 0)) : 5'($urandom_range(31, 0));
            rw = 1'($urandom_range(1, 0));
            rd = 8'($urandom);
            model_step(rw, ra, rd, erd, eerr, elat);
            do_txn($sformatf("rand%0d", i), rw, ra, rd, erd, eerr, elat);
        end

        // req held high: alternating write 0x3C / read at 29, back to back.
        @(negedge clock);
        req = 1'b1; we = 1'b1; addr = 5'd29; wdata = 8'h3C;
        last_ack = 0; xbad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int n = 0; n < 12 && !got; n++) begin
                @(negedge clock);
                if ((load_MAR || load_MDR || MDR_bus) && $isunknown(sysbus)) xbad = 1'b1;
                if (ack) got = 1'b1;
            end
            chk($sformatf("b2b%0d.ack_seen", k), {31'd0, got}, 32'd1);
            if (k > 0) chk($sformatf("b2b%0d.spacing", k), cyc - last_ack, (k % 2 == 1) ? 5 : WL + 1);
            if (k % 2 == 1) chk($sformatf("b2b%0d.rdata", k), {24'd0, rdata}, 32'h3C);
            last_ack = cyc;
            we = ~we;
            if (k == 3) req = 1'b0;
        end
        chk("b2b.sysbus_known", {31'd0, xbad}, 32'd0);
        refmem[29] = 8'h3C; ref_rdata = 8'h3C;
        @(negedge clock);

`ifdef RAM_INITIATOR_WRVERIFY_EN
        // Write verify against a RAM with data bit 0 stuck at 0.
        stuck0 = 1'b1;
        do_txn("verify.bad", 1'b1, 5'd20, 8'h01, ref_rdata, 1'b1, 6);
        do_txn("verify.good", 1'b1, 5'd20, 8'h02, ref_rdata, 1'b0, 6);
        stuck0 = 1'b0;
        refmem[20] = 8'h02;
        model_step(1'b0, 5'd20, 8'h00, erd, eerr, elat);
        do_txn("verify.readback", 1'b0, 5'd20, 8'h00, erd, eerr, elat);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
